// File: rtl/dii_host_gateway_pkg.sv
// Shared types for the multi-host DII gateway: flit layout, FSM encodings
// and small index helpers used by the gateway and its round-robin arbiter.
package dii_host_gateway_pkg;

    localparam int DII_ADDR_W = 16;

    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [DII_ADDR_W-1:0] data;
    } dii_flit;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_t;

    typedef enum logic [1:0] {
        DS_HDR,
        DS_SEND_HDR,
        DS_PASS,
        DS_DROP
    } ds_state_t;

    // A single port still needs a one-bit index so every select stays legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dii_host_gateway_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above
// the pointer, wrapping around; intended for reuse by ring multiplexers.
module dii_rr_arbiter
    import dii_host_gateway_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [NUM_REQ-1:0] rotated;
    int                 grant_pos;
    int                 grant_abs;

    // Rotate so bit 0 is the pointer position; scanning downward lets the
    // lowest rotated position win without an early loop exit.
    always_comb begin
        rotated     = NUM_REQ'({req, req} >> ptr);
        grant_pos   = 0;
        grant_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                grant_valid = 1'b1;
                grant_pos   = k;
            end
        end
        grant_abs = int'(ptr) + grant_pos;
        if (grant_abs >= NUM_REQ) begin
            grant_abs = grant_abs - NUM_REQ;
        end
        grant_idx    = IDX_W'(grant_abs);
        grant_onehot = grant_valid ? (NUM_REQ'(1) << grant_abs) : '0;
    end

endmodule

// File: rtl/dii_host_gateway.sv
// Bridges NUM_HOSTS host DII streams to one router ext port: packet-atomic
// round-robin merge upstream, address-based routing with drop counting downstream.
module dii_host_gateway
    import dii_host_gateway_pkg::*;
#(
    parameter int                    NUM_HOSTS      = 2,
    parameter logic [DII_ADDR_W-1:0] HOST_ID_BASE   = 16'h8000,
    parameter int                    DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  dii_flit                   host_in [NUM_HOSTS],
    output logic [NUM_HOSTS-1:0]      host_in_ready,
    output dii_flit                   host_out [NUM_HOSTS],
    input  logic [NUM_HOSTS-1:0]      host_out_ready,
    output dii_flit                   ext_out,
    input  logic                      ext_out_ready,
    input  dii_flit                   ext_in,
    output logic                      ext_in_ready,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam int IDX_W = idx_width(NUM_HOSTS);

    arb_state_t            arb_state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      lock_idx;
    logic [NUM_HOSTS-1:0]  req;
    logic [NUM_HOSTS-1:0]  arb_onehot;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_valid;
    logic [IDX_W-1:0]      cur_idx;
    dii_flit               cur_flit;
    logic                  up_xfer;

    ds_state_t             ds_state;
    dii_flit               hdr;
    logic [IDX_W-1:0]      tgt;
    logic [DII_ADDR_W-1:0] hdr_idx;
    logic                  hdr_mapped;
    logic                  ds_xfer;
    logic                  drop_inc;

    always_comb begin
        for (int i = 0; i < NUM_HOSTS; i++) begin
            req[i] = host_in[i].valid;
        end
    end

    dii_rr_arbiter #(
        .NUM_REQ(NUM_HOSTS),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req         (req),
        .ptr         (rr_ptr),
        .grant_onehot(arb_onehot),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // While locked only the owning port is visible, so other valids cannot
    // interleave flits into the packet in flight.
    always_comb begin
        cur_idx       = (arb_state == ARB_LOCK) ? lock_idx : arb_idx;
        cur_flit      = host_in[cur_idx];
        ext_out       = cur_flit;
        ext_out.valid = rst && ((arb_state == ARB_LOCK) ? cur_flit.valid : arb_valid);
        host_in_ready = '0;
        if (rst) begin
            if (arb_state == ARB_LOCK) begin
                host_in_ready[lock_idx] = ext_out_ready;
            end else begin
                host_in_ready = arb_onehot & {NUM_HOSTS{ext_out_ready}};
            end
        end
        up_xfer = ext_out.valid && ext_out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            arb_state <= ARB_IDLE;
            rr_ptr    <= '0;
            lock_idx  <= '0;
        end else if (up_xfer) begin
            if (cur_flit.last) begin
                arb_state <= ARB_IDLE;
                rr_ptr    <= IDX_W'(wrap_inc(int'(cur_idx), NUM_HOSTS));
            end else begin
                arb_state <= ARB_LOCK;
                lock_idx  <= cur_idx;
            end
        end
    end

    assign hdr_idx    = ext_in.data - HOST_ID_BASE;
    assign hdr_mapped = hdr_idx < DII_ADDR_W'(NUM_HOSTS);

    // The header is replayed from hdr one cycle later; payload bypasses
    // straight through so only the header costs latency.
    always_comb begin
        ext_in_ready = 1'b0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            host_out[i] = '0;
        end
        case (ds_state)
            DS_HDR:      ext_in_ready = !hdr.valid;
            DS_SEND_HDR: host_out[tgt] = hdr;
            DS_PASS: begin
                host_out[tgt] = ext_in;
                ext_in_ready  = host_out_ready[tgt];
            end
            DS_DROP:     ext_in_ready = 1'b1;
            default:     ext_in_ready = 1'b0;
        endcase
        if (!rst) begin
            ext_in_ready = 1'b1;
            for (int i = 0; i < NUM_HOSTS; i++) begin
                host_out[i].valid = 1'b0;
            end
        end
        ds_xfer  = ext_in.valid && ext_in_ready;
        drop_inc = ds_xfer && ext_in.last &&
                   (((ds_state == DS_HDR) && !hdr_mapped) || (ds_state == DS_DROP));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ds_state <= DS_HDR;
            hdr      <= '0;
            tgt      <= '0;
        end else begin
            case (ds_state)
                DS_HDR: begin
                    if (ds_xfer) begin
                        if (hdr_mapped) begin
                            hdr      <= ext_in;
                            tgt      <= IDX_W'(hdr_idx);
                            ds_state <= DS_SEND_HDR;
                        end else if (!ext_in.last) begin
                            ds_state <= DS_DROP;
                        end
                    end
                end
                DS_SEND_HDR: begin
                    if (host_out_ready[tgt]) begin
                        hdr.valid <= 1'b0;
                        ds_state  <= hdr.last ? DS_HDR : DS_PASS;
                    end
                end
                DS_PASS: begin
                    if (ds_xfer && ext_in.last) begin
                        ds_state <= DS_HDR;
                    end
                end
                DS_DROP: begin
                    if (ds_xfer && ext_in.last) begin
                        ds_state <= DS_HDR;
                    end
                end
                default: ds_state <= DS_HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_count <= '0;
        end else if (drop_inc && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_dii_host_gateway.sv
// Scoreboard bench for dii_host_gateway: per-port source queues feed the DUT,
// expected flits are queued at issue time and a negedge monitor checks them.
module tb_dii_host_gateway;
    import dii_host_gateway_pkg::*;

    localparam int NH   = 3;
    localparam int DCW  = 2;
    localparam int EXT  = NH;
    localparam int NONE = -1;

    logic           clk = 1'b0;
    logic           rst;
    dii_flit        host_in [NH];
    logic [NH-1:0]  host_in_ready;
    dii_flit        host_out [NH];
    logic [NH-1:0]  host_out_ready;
    dii_flit        ext_out;
    logic           ext_out_ready;
    dii_flit        ext_in;
    logic           ext_in_ready;
    logic [DCW-1:0] drop_count;

    dii_flit        src_q [NH+1][$];
    dii_flit        exp_q [NH+1][$];
    logic [NH:0]    fired;
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;

    dii_host_gateway #(
        .NUM_HOSTS     (NH),
        .HOST_ID_BASE  (16'h8000),
        .DROP_CNT_WIDTH(DCW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_in       (host_in),
        .host_in_ready (host_in_ready),
        .host_out      (host_out),
        .host_out_ready(host_out_ready),
        .ext_out       (ext_out),
        .ext_out_ready (ext_out_ready),
        .ext_in        (ext_in),
        .ext_in_ready  (ext_in_ready),
        .drop_count    (drop_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // src: host index or EXT for the router side; dst: host index, EXT or NONE.
    task automatic applyStimulus(input int src, input logic [15:0] data, input bit last, input int dst);
        dii_flit f;
        f.valid = 1'b1;
        f.last  = last;
        f.data  = data;
        src_q[src].push_back(f);
        if (dst != NONE) exp_q[dst].push_back(f);
    endtask

    function automatic int pending();
        int n = 0;
        for (int s = 0; s <= NH; s++) n += src_q[s].size() + exp_q[s].size();
        return n;
    endfunction

    task automatic waitIdle(input string name);
        int budget = 200;
        while (pending() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(negedge clk);
        checkOutput(name, pending(), 0);
    endtask

    task automatic applyReset();
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
    endtask

    // Driver: retire accepted flits just after the edge, then present heads.
    initial begin
        for (int h = 0; h < NH; h++) host_in[h] = '0;
        ext_in = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s <= NH; s++) begin
                if (fired[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
            end
            for (int h = 0; h < NH; h++) host_in[h] = (src_q[h].size() > 0) ? src_q[h][0] : '0;
            ext_in = (src_q[EXT].size() > 0) ? src_q[EXT][0] : '0;
        end
    end

    // Monitor: every handshake on an output must match the next queued flit.
    initial begin
        dii_flit f;
        fired = '0;
        forever begin
            @(negedge clk);
            for (int h = 0; h < NH; h++) fired[h] = host_in[h].valid && host_in_ready[h];
            fired[EXT] = ext_in.valid && ext_in_ready;
            if (ext_out.valid && ext_out_ready) begin
                if (exp_q[EXT].size() == 0) begin
                    checkOutput("ext_out_unexpected", {15'd0, ext_out.valid, ext_out.data}, 32'd0);
                end else begin
                    f = exp_q[EXT].pop_front();
                    checkOutput("ext_out_flit", {15'd0, ext_out.last, ext_out.data}, {15'd0, f.last, f.data});
                end
            end
            for (int h = 0; h < NH; h++) begin
                if (host_out[h].valid) begin
                    if (exp_q[h].size() == 0) begin
                        checkOutput($sformatf("host_out%0d_unexpected", h), {15'd0, host_out[h].valid, host_out[h].data}, 32'd0);
                    end else if (host_out_ready[h]) begin
                        f = exp_q[h].pop_front();
                        checkOutput($sformatf("host_out%0d_flit", h), {15'd0, host_out[h].last, host_out[h].data},
                                    {15'd0, f.last, f.data});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] drop_dest [3];
        logic [1:0]  drop_exp [3];
        int          n;
        bit          seen;

        rst            = 1'b0;
        ext_out_ready  = 1'b0;
        host_out_ready = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ext_out_valid", ext_out.valid, 0);
        checkOutput("rst_host_out_valid", {host_out[2].valid, host_out[1].valid, host_out[0].valid}, 0);
        checkOutput("rst_host_in_ready", host_in_ready, 0);
        checkOutput("rst_ext_in_ready", ext_in_ready, 1);
        checkOutput("rst_drop_count", drop_count, 0);
        @(posedge clk); #2;
        rst           = 1'b1;
        ext_out_ready = 1'b1;

        // Reset in the middle of a host1 packet.
        for (int f = 0; f < 5; f++) applyStimulus(1, 16'h1100 + 16'(f), f == 4, (f < 3) ? EXT : NONE);
        n = 0;
        for (int i = 0; i < 30 && n < 3; i++) begin
            @(negedge clk);
            if (host_in[1].valid && host_in_ready[1]) n++;
        end
        checkOutput("mid_packet_flits", n, 3);
        @(posedge clk); #2;
        rst = 1'b0;
        src_q[1].delete();
        applyStimulus(0, 16'h0A01, 1'b1, EXT);
        @(negedge clk);
        checkOutput("mid_rst_ext_out_valid", ext_out.valid, 0);
        checkOutput("mid_rst_host_in_ready", host_in_ready, 0);
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ext_out_valid", ext_out.valid, 1);
        checkOutput("post_rst_ext_out_data", ext_out.data, 16'h0A01);
        checkOutput("post_rst_host_in_ready", host_in_ready, 3'b001);
        waitIdle("reset_drain");

        // Round robin with all three hosts holding two 2-flit packets.
        applyReset();
        for (int p = 0; p < 2; p++)
            for (int h = 0; h < NH; h++)
                for (int f = 0; f < 2; f++)
                    applyStimulus(h, 16'hB000 | 16'(h << 8) | 16'(p << 4) | 16'(f), f == 1, EXT);
        waitIdle("rr_drain");

        // Lock under backpressure: host1 waits behind host0's 4-flit packet.
        for (int f = 0; f < 4; f++) applyStimulus(0, 16'hC000 + 16'(f), f == 3, EXT);
        applyStimulus(1, 16'hC100, 1'b1, EXT);
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #2 ext_out_ready = ~ext_out_ready;
            @(negedge clk);
            if (host_in_ready[1] && src_q[0].size() > 0) seen = 1'b1;
        end
        checkOutput("lock_host1_held_off", seen, 0);
        ext_out_ready = 1'b1;
        waitIdle("lock_drain");

        // Downstream routing to host1 with one-cycle header latency.
        applyStimulus(EXT, 16'h8001, 1'b0, 1);
        applyStimulus(EXT, 16'h0000, 1'b0, 1);
        applyStimulus(EXT, 16'h1234, 1'b1, 1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ext_in.valid && ext_in_ready && ext_in.data == 16'h8001) seen = 1'b1;
        end
        checkOutput("route_hdr_accepted", seen, 1);
        @(negedge clk);
        checkOutput("route_hdr_valid", host_out[1].valid, 1);
        checkOutput("route_hdr_data", host_out[1].data, 16'h8001);
        checkOutput("route_hdr_ext_in_ready", ext_in_ready, 0);
        checkOutput("route_host0_quiet", host_out[0].valid, 0);
        waitIdle("route_drain");

        // Host2 backpressure holds the header and stalls the router side.
        host_out_ready[2] = 1'b0;
        applyStimulus(EXT, 16'h8002, 1'b0, 2);
        applyStimulus(EXT, 16'h2222, 1'b0, 2);
        applyStimulus(EXT, 16'h3333, 1'b1, 2);
        repeat (4) @(negedge clk);
        checkOutput("bp_hdr_valid", host_out[2].valid, 1);
        checkOutput("bp_hdr_data", host_out[2].data, 16'h8002);
        checkOutput("bp_ext_in_ready", ext_in_ready, 0);
        @(posedge clk); #2 host_out_ready[2] = 1'b1;
        applyStimulus(EXT, 16'h8000, 1'b0, 0);
        applyStimulus(EXT, 16'h00AA, 1'b1, 0);
        waitIdle("bp_drain");

        // Drop path: unmapped multi-flit packet, then unmapped single flit.
        applyStimulus(EXT, 16'h0005, 1'b0, NONE);
        applyStimulus(EXT, 16'hAAAA, 1'b0, NONE);
        applyStimulus(EXT, 16'hBBBB, 1'b1, NONE);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ext_in.valid) checkOutput("drop_ext_in_ready", ext_in_ready, 1);
        end
        waitIdle("drop1_drain");
        checkOutput("drop_count_1", drop_count, 1);
        applyStimulus(EXT, 16'h8003, 1'b1, NONE);
        waitIdle("drop2_drain");
        checkOutput("drop_count_2", drop_count, 2);

        // Saturation of the 2-bit counter.
        drop_dest = '{16'h0000, 16'h7FFF, 16'h8010};
        drop_exp  = '{2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(EXT, drop_dest[i], 1'b1, NONE);
            waitIdle("sat_drain");
            checkOutput($sformatf("drop_count_sat%0d", i), drop_count, 32'(drop_exp[i]));
        end

        checkOutput("final_queues_empty", pending(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
